// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, function codes, ALU operations,
// operand-select polarities and the issue-history record.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [5:0] {
        ALU_ADD  = 6'd0,
        ALU_SUB  = 6'd1,
        ALU_AND  = 6'd2,
        ALU_OR   = 6'd3,
        ALU_XOR  = 6'd4,
        ALU_NOR  = 6'd5,
        ALU_SLT  = 6'd6,
        ALU_SLTU = 6'd7,
        ALU_SLL  = 6'd8,
        ALU_SRL  = 6'd9,
        ALU_SRA  = 6'd10
    } alu_op_e;

    localparam logic SA1_NUM   = 1'b1;
    localparam logic SA1_SHRMT = 1'b0;
    localparam logic SA2_RD1   = 1'b1;
    localparam logic SA2_SA1   = 1'b0;
    localparam logic SB_RD2    = 1'b1;
    localparam logic SB_NUM    = 1'b0;
    localparam logic SWD_MEM   = 1'b1;
    localparam logic SWD_ALU   = 1'b0;

    typedef struct packed {
        logic       dmem_we;
        logic       reg_we;
        logic       sa1;
        logic       sa2;
        logic       sb;
        logic       swd;
        logic [4:0] wra;
        logic [5:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wra;
    } hist_t;

    function automatic logic hist_hit(input logic [4:0] r, input hist_t h0, input hist_t h1);
        return (r != 5'd0) && ((h0.valid && (h0.wra == r)) || (h1.valid && (h1.wra == r)));
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: reg0 hardwired to zero, two
// combinational reads with write-through from the writeback port.
module reg_file
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we && (waddr == raddr1)) rdata1 = wdata;
        if (we && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == 5'd0) rdata1 = '0;
        if (raddr2 == 5'd0) rdata2 = '0;
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: instruction register, decoder, register-file read and
// RAW interlock against the two most recently issued destinations.
module id_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_ID_instr,
    input  logic        i_ID_wbWe,
    input  logic [4:0]  i_ID_wbAddr,
    input  logic [31:0] i_ID_wbData,
    output logic        o_ID_stall,
    output logic        o_ID_illegal,
    output logic        o_ID_dmemWe,
    output logic        o_ID_regWe,
    output logic        o_ID_sA1,
    output logic        o_ID_sA2,
    output logic        o_ID_sB,
    output logic        o_ID_sWD,
    output logic [4:0]  o_ID_WRA,
    output logic [5:0]  o_ID_ALUop,
    output logic [31:0] o_ID_rd1,
    output logic [31:0] o_ID_rd2,
    output logic [31:0] o_ID_num,
    output logic [31:0] o_ID_shrmt
);

    logic [31:0] ir;
    hist_t       hist0, hist1;
    ctrl_t       dec, issued;
    logic [31:0] num;
    logic        use_rs, use_rt, dec_illegal;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

    reg_file u_reg_file (
        .clk    (clk),
        .rstn   (rstn),
        .we     (i_ID_wbWe),
        .waddr  (i_ID_wbAddr),
        .wdata  (i_ID_wbData),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (o_ID_rd1),
        .rdata2 (o_ID_rd2)
    );

    always_comb begin
        dec         = '0;
        num         = '0;
        use_rs      = 1'b0;
        use_rt      = 1'b0;
        dec_illegal = 1'b0;
        if (opcode == OP_RTYPE) begin
            dec.sa2 = SA2_RD1;
            dec.sb  = SB_RD2;
            dec.reg_we = 1'b1;
            dec.wra = rd;
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            case (funct)
                FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                FN_AND:  dec.alu_op = ALU_AND;
                FN_OR:   dec.alu_op = ALU_OR;
                FN_XOR:  dec.alu_op = ALU_XOR;
                FN_NOR:  dec.alu_op = ALU_NOR;
                FN_SLT:  dec.alu_op = ALU_SLT;
                FN_SLTU: dec.alu_op = ALU_SLTU;
                FN_SLL, FN_SRL, FN_SRA: begin
                    dec.alu_op = (funct == FN_SLL) ? ALU_SLL :
                                 (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                    dec.sa2 = SA2_SA1;
                    dec.sa1 = SA1_SHRMT;
                    use_rs  = 1'b0;
                end
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            dec.sa2    = SA2_RD1;
            dec.sb     = SB_NUM;
            dec.reg_we = 1'b1;
            dec.wra    = rt;
            use_rs     = 1'b1;
            num        = {{16{imm[15]}}, imm};
            case (opcode)
                OP_ADDI, OP_ADDIU: dec.alu_op = ALU_ADD;
                OP_SLTI:  dec.alu_op = ALU_SLT;
                OP_SLTIU: dec.alu_op = ALU_SLTU;
                OP_ANDI: begin dec.alu_op = ALU_AND; num = {16'h0, imm}; end
                OP_ORI:  begin dec.alu_op = ALU_OR;  num = {16'h0, imm}; end
                OP_XORI: begin dec.alu_op = ALU_XOR; num = {16'h0, imm}; end
                OP_LUI:  begin num = {imm, 16'h0}; use_rs = 1'b0; end
                OP_LW:   dec.swd = SWD_MEM;
                OP_SW: begin
                    dec.dmem_we = 1'b1;
                    dec.reg_we  = 1'b0;
                    dec.wra     = 5'd0;
                    use_rt      = 1'b1;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
        if (dec.wra == 5'd0) dec.reg_we = 1'b0;
        // All-zero word is the reset/nop bubble, not a real sll to $0
        if (dec_illegal || (ir == '0)) begin
            dec    = '0;
            num    = '0;
            use_rs = 1'b0;
            use_rt = 1'b0;
        end
    end

    assign o_ID_stall = (use_rs && hist_hit(rs, hist0, hist1)) ||
                        (use_rt && hist_hit(rt, hist0, hist1));
    assign issued     = o_ID_stall ? '0 : dec;

    assign o_ID_illegal = dec_illegal && !o_ID_stall;
    assign o_ID_dmemWe  = issued.dmem_we;
    assign o_ID_regWe   = issued.reg_we;
    assign o_ID_sA1     = issued.sa1;
    assign o_ID_sA2     = issued.sa2;
    assign o_ID_sB      = issued.sb;
    assign o_ID_sWD     = issued.swd;
    assign o_ID_WRA     = issued.wra;
    assign o_ID_ALUop   = issued.alu_op;
    assign o_ID_num     = num;
    assign o_ID_shrmt   = {27'b0, shamt};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir    <= '0;
            hist0 <= '0;
            hist1 <= '0;
        end else begin
            if (!o_ID_stall) ir <= i_ID_instr;
            hist1       <= hist0;
            hist0.valid <= issued.reg_we;
            hist0.wra   <= issued.wra;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written
// hazard/write-through/reset sequences and a randomized stream vs. a model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] i_ID_instr;
    logic        i_ID_wbWe;
    logic [4:0]  i_ID_wbAddr;
    logic [31:0] i_ID_wbData;
    logic        o_ID_stall, o_ID_illegal, o_ID_dmemWe, o_ID_regWe;
    logic        o_ID_sA1, o_ID_sA2, o_ID_sB, o_ID_sWD;
    logic [4:0]  o_ID_WRA;
    logic [5:0]  o_ID_ALUop;
    logic [31:0] o_ID_rd1, o_ID_rd2, o_ID_num, o_ID_shrmt;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_ID_instr   (i_ID_instr),
        .i_ID_wbWe    (i_ID_wbWe),
        .i_ID_wbAddr  (i_ID_wbAddr),
        .i_ID_wbData  (i_ID_wbData),
        .o_ID_stall   (o_ID_stall),
        .o_ID_illegal (o_ID_illegal),
        .o_ID_dmemWe  (o_ID_dmemWe),
        .o_ID_regWe   (o_ID_regWe),
        .o_ID_sA1     (o_ID_sA1),
        .o_ID_sA2     (o_ID_sA2),
        .o_ID_sB      (o_ID_sB),
        .o_ID_sWD     (o_ID_sWD),
        .o_ID_WRA     (o_ID_WRA),
        .o_ID_ALUop   (o_ID_ALUop),
        .o_ID_rd1     (o_ID_rd1),
        .o_ID_rd2     (o_ID_rd2),
        .o_ID_num     (o_ID_num),
        .o_ID_shrmt   (o_ID_shrmt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] regs_m [32];
    int r_alu[int];
    int sh_alu[int];
    int i_alu[int];

    typedef struct {
        bit legal;
        bit wr;
        int dst;
        int alu;
        int src_a;
        int src_b;
    } mdec_t;

    function automatic mdec_t mdecode(input logic [31:0] w);
        mdec_t d;
        int op, fn, rs, rt, rd;
        op = int'(w[31:26]); fn = int'(w[5:0]);
        rs = int'(w[25:21]); rt = int'(w[20:16]); rd = int'(w[15:11]);
        d = '{legal: 1'b1, wr: 1'b1, dst: 0, alu: 0, src_a: -1, src_b: -1};
        if (w == 32'h0) begin
            d.wr = 1'b0;
            return d;
        end
        if (op == 0) begin
            if (r_alu.exists(fn)) begin
                d.alu = r_alu[fn]; d.src_a = rs; d.src_b = rt; d.dst = rd;
            end else if (sh_alu.exists(fn)) begin
                d.alu = sh_alu[fn]; d.src_b = rt; d.dst = rd;
            end else d.legal = 1'b0;
        end else if (i_alu.exists(op)) begin
            d.alu = i_alu[op]; d.src_a = rs; d.dst = rt;
        end else if (op == 'h0F) begin
            d.dst = rt;
        end else if (op == 'h23) begin
            d.src_a = rs; d.dst = rt;
        end else if (op == 'h2B) begin
            d.src_a = rs; d.src_b = rt; d.wr = 1'b0;
        end else d.legal = 1'b0;
        if (!d.legal) begin
            d.wr = 1'b0; d.dst = 0; d.alu = 0; d.src_a = -1; d.src_b = -1;
        end
        if (d.dst == 0) d.wr = 1'b0;
        if (d.src_a == 0) d.src_a = -1;
        if (d.src_b == 0) d.src_b = -1;
        return d;
    endfunction

    function automatic logic [31:0] read_m(input int r);
        if (r == 0) return 32'h0;
        if (i_ID_wbWe && (int'(i_ID_wbAddr) == r)) return i_ID_wbData;
        return regs_m[r];
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        reg_we, dmem_we, sa1, sa2, sb, swd;
        logic [4:0]  wra;
        logic [5:0]  alu;
        logic        chk_num;
        logic [31:0] num;
        logic        illegal;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic do_reset();
        rstn = 1'b0;
        i_ID_instr = '0; i_ID_wbWe = 1'b0; i_ID_wbAddr = '0; i_ID_wbData = '0;
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input int a, input logic [31:0] d);
        i_ID_wbWe = 1'b1; i_ID_wbAddr = 5'(a); i_ID_wbData = d;
        @(posedge clk);
        #1;
        if (a != 0) regs_m[a] = d;
        i_ID_wbWe = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  fr [10];
        logic [5:0]  fs [3];
        logic [5:0]  oi [7];
        fr = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        fs = '{6'h00, 6'h02, 6'h03};
        oi = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
        rs = 5'($urandom_range(0, 5)); rt = 5'($urandom_range(0, 5));
        rd = 5'($urandom_range(0, 5)); sh = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 7: return {6'h00, rs, rt, rd, 5'd0, fr[$urandom_range(0, 9)]};
            1:    return {6'h00, 5'd0, rt, rd, sh, fs[$urandom_range(0, 2)]};
            2, 8: return {oi[$urandom_range(0, 6)], rs, rt, imm};
            3:    return {6'h0F, 5'd0, rt, imm};
            4:    return {6'h23, rs, rt, imm};
            5:    return {6'h2B, rs, rt, imm};
            6:    return {6'h3F, 26'($urandom)};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        mdec_t md;
        logic [31:0] ir_m, cur, nxt;
        int h0, h1, iss;
        bit stall_e;
        logic we_r;
        int a_r;
        logic [31:0] d_r;

        r_alu[32'h20] = 0; r_alu[32'h21] = 0; r_alu[32'h22] = 1; r_alu[32'h23] = 1;
        r_alu[32'h24] = 2; r_alu[32'h25] = 3; r_alu[32'h26] = 4; r_alu[32'h27] = 5;
        r_alu[32'h2A] = 6; r_alu[32'h2B] = 7;
        sh_alu[0] = 8; sh_alu[2] = 9; sh_alu[3] = 10;
        i_alu[32'h08] = 0; i_alu[32'h09] = 0; i_alu[32'h0A] = 6; i_alu[32'h0B] = 7;
        i_alu[32'h0C] = 2; i_alu[32'h0D] = 3; i_alu[32'h0E] = 4;

        //            instr         rW dW a1 a2 sB WD WRA   ALU  cN num           ill
        vecs[0]  = '{32'h20010005, 1, 0, 0, 1, 0, 0, 5'd1,  6'd0,  1, 32'h00000005, 0};
        vecs[1]  = '{32'h3064FFFF, 1, 0, 0, 1, 0, 0, 5'd4,  6'd2,  1, 32'h0000FFFF, 0};
        vecs[2]  = '{32'h28C5FFFF, 1, 0, 0, 1, 0, 0, 5'd5,  6'd6,  1, 32'hFFFFFFFF, 0};
        vecs[3]  = '{32'h3C071234, 1, 0, 0, 1, 0, 0, 5'd7,  6'd0,  1, 32'h12340000, 0};
        vecs[4]  = '{32'h8CA60004, 1, 0, 0, 1, 0, 1, 5'd6,  6'd0,  1, 32'h00000004, 0};
        vecs[5]  = '{32'hACA60008, 0, 1, 0, 1, 0, 0, 5'd0,  6'd0,  1, 32'h00000008, 0};
        vecs[6]  = '{32'h012A4022, 1, 0, 0, 1, 1, 0, 5'd8,  6'd1,  0, 32'h0,        0};
        vecs[7]  = '{32'h018D5827, 1, 0, 0, 1, 1, 0, 5'd11, 6'd5,  0, 32'h0,        0};
        vecs[8]  = '{32'h0022702B, 1, 0, 0, 1, 1, 0, 5'd14, 6'd7,  0, 32'h0,        0};
        vecs[9]  = '{32'h00021903, 1, 0, 0, 0, 1, 0, 5'd3,  6'd10, 0, 32'h0,        0};
        vecs[10] = '{32'h00107FC2, 1, 0, 0, 0, 1, 0, 5'd15, 6'd9,  0, 32'h0,        0};
        vecs[11] = '{32'h00220020, 0, 0, 0, 1, 1, 0, 5'd0,  6'd0,  0, 32'h0,        0};
        vecs[12] = '{32'h38418000, 1, 0, 0, 1, 0, 0, 5'd1,  6'd4,  1, 32'h00008000, 0};
        vecs[13] = '{32'h24418000, 1, 0, 0, 1, 0, 0, 5'd1,  6'd0,  1, 32'hFFFF8000, 0};
        vecs[14] = '{32'hFC000000, 0, 0, 0, 0, 0, 0, 5'd0,  6'd0,  0, 32'h0,        1};
        vecs[15] = '{32'h00000001, 0, 0, 0, 0, 0, 0, 5'd0,  6'd0,  0, 32'h0,        1};
        vecs[16] = '{32'h00084840, 1, 0, 0, 0, 1, 0, 5'd9,  6'd8,  0, 32'h0,        0};

        // Reset values
        rstn = 1'b0;
        i_ID_instr = '0; i_ID_wbWe = 1'b0; i_ID_wbAddr = '0; i_ID_wbData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", o_ID_stall, 0);     check("rst_illegal", o_ID_illegal, 0);
        check("rst_dmemWe", o_ID_dmemWe, 0);   check("rst_regWe", o_ID_regWe, 0);
        check("rst_sA1", o_ID_sA1, 0);         check("rst_sA2", o_ID_sA2, 0);
        check("rst_sB", o_ID_sB, 0);           check("rst_sWD", o_ID_sWD, 0);
        check("rst_WRA", o_ID_WRA, 0);         check("rst_ALUop", o_ID_ALUop, 0);
        check("rst_rd1", o_ID_rd1, 0);         check("rst_rd2", o_ID_rd2, 0);
        check("rst_num", o_ID_num, 0);         check("rst_shrmt", o_ID_shrmt, 0);

        do_reset();
        check("nop_stall", o_ID_stall, 0);
        check("nop_regWe", o_ID_regWe, 0);

        // Directed vector table with preloaded registers
        for (int i = 1; i < 32; i++) wb_write(i, 32'h01010101 * i);
        wb_write(2, 32'h80000000);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NV; k++) begin
            cur = vecs[k].instr;
            i_ID_instr = cur;
            @(posedge clk);
            #1;
            i_ID_instr = '0;
            check($sformatf("v%0d_stall", k), o_ID_stall, 0);
            check($sformatf("v%0d_regWe", k), o_ID_regWe, vecs[k].reg_we);
            check($sformatf("v%0d_dmemWe", k), o_ID_dmemWe, vecs[k].dmem_we);
            check($sformatf("v%0d_sA1", k), o_ID_sA1, vecs[k].sa1);
            check($sformatf("v%0d_sA2", k), o_ID_sA2, vecs[k].sa2);
            check($sformatf("v%0d_sB", k), o_ID_sB, vecs[k].sb);
            check($sformatf("v%0d_sWD", k), o_ID_sWD, vecs[k].swd);
            check($sformatf("v%0d_WRA", k), o_ID_WRA, vecs[k].wra);
            check($sformatf("v%0d_ALUop", k), o_ID_ALUop, vecs[k].alu);
            check($sformatf("v%0d_illegal", k), o_ID_illegal, vecs[k].illegal);
            check($sformatf("v%0d_shrmt", k), o_ID_shrmt, {27'b0, cur[10:6]});
            if (vecs[k].chk_num) check($sformatf("v%0d_num", k), o_ID_num, vecs[k].num);
            if (!vecs[k].illegal) begin
                check($sformatf("v%0d_rd1", k), o_ID_rd1, regs_m[cur[25:21]]);
                check($sformatf("v%0d_rd2", k), o_ID_rd2, regs_m[cur[20:16]]);
            end
            repeat (2) @(posedge clk);
            #1;
        end

        // addi $1 then add $2,$1,$1: two stall cycles, then issue with fresh $1
        do_reset();
        i_ID_instr = 32'h20010005;
        @(posedge clk); #1;
        check("haz_addi_regWe", o_ID_regWe, 1);
        check("haz_addi_WRA", o_ID_WRA, 1);
        i_ID_instr = 32'h00211020;
        @(posedge clk); #1;
        i_ID_instr = '0;
        check("haz_c1_stall", o_ID_stall, 1);
        check("haz_c1_regWe", o_ID_regWe, 0);
        check("haz_c1_WRA", o_ID_WRA, 0);
        @(posedge clk); #1;
        check("haz_c2_stall", o_ID_stall, 1);
        i_ID_wbWe = 1'b1; i_ID_wbAddr = 5'd1; i_ID_wbData = 32'd5;
        @(posedge clk); #1;
        i_ID_wbWe = 1'b0;
        check("haz_c3_stall", o_ID_stall, 0);
        check("haz_add_regWe", o_ID_regWe, 1);
        check("haz_add_WRA", o_ID_WRA, 2);
        check("haz_add_rd1", o_ID_rd1, 5);
        check("haz_add_rd2", o_ID_rd2, 5);

        // Write-through while lw $6,4($5) is decoded
        do_reset();
        i_ID_instr = 32'h8CA60004;
        @(posedge clk); #1;
        i_ID_instr = '0;
        i_ID_wbWe = 1'b1; i_ID_wbAddr = 5'd5; i_ID_wbData = 32'hDEADBEEF;
        #1;
        check("wt_rd1", o_ID_rd1, 32'hDEADBEEF);
        check("wt_num", o_ID_num, 4);
        check("wt_sWD", o_ID_sWD, 1);
        check("wt_WRA", o_ID_WRA, 6);
        @(posedge clk); #1;
        i_ID_wbWe = 1'b0;

        // Illegal word is a one-cycle bubble; following instruction issues
        i_ID_instr = 32'hFC000000;
        @(posedge clk); #1;
        i_ID_instr = 32'h20010005;
        check("ill_illegal", o_ID_illegal, 1);
        check("ill_regWe", o_ID_regWe, 0);
        @(posedge clk); #1;
        i_ID_instr = '0;
        check("ill_next_illegal", o_ID_illegal, 0);
        check("ill_next_regWe", o_ID_regWe, 1);
        check("ill_next_WRA", o_ID_WRA, 1);

        // Asynchronous reset in the middle of a stall
        do_reset();
        i_ID_instr = 32'h20010005;
        @(posedge clk); #1;
        i_ID_instr = 32'h00211020;
        @(posedge clk); #1;
        check("rms_stall_before", o_ID_stall, 1);
        rstn = 1'b0;
        #1;
        check("rms_stall", o_ID_stall, 0);
        check("rms_regWe", o_ID_regWe, 0);
        check("rms_WRA", o_ID_WRA, 0);
        i_ID_instr = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rms_after_stall", o_ID_stall, 0);
        check("rms_after_regWe", o_ID_regWe, 0);

        // Randomized stream against the model
        do_reset();
        ir_m = '0; h0 = -1; h1 = -1;
        for (int c = 0; c < 600; c++) begin
            nxt  = gen_instr();
            we_r = 1'($urandom_range(0, 1));
            a_r  = $urandom_range(0, 7);
            d_r  = $urandom;
            i_ID_instr = nxt; i_ID_wbWe = we_r; i_ID_wbAddr = 5'(a_r); i_ID_wbData = d_r;
            #1;
            md = mdecode(ir_m);
            stall_e = (md.src_a > 0 && (md.src_a == h0 || md.src_a == h1)) ||
                      (md.src_b > 0 && (md.src_b == h0 || md.src_b == h1));
            check("rnd_stall", o_ID_stall, stall_e);
            if (stall_e) begin
                check("rnd_bub_regWe", o_ID_regWe, 0);
                check("rnd_bub_WRA", o_ID_WRA, 0);
                check("rnd_bub_illegal", o_ID_illegal, 0);
                iss = -1;
            end else begin
                check("rnd_regWe", o_ID_regWe, md.wr);
                check("rnd_WRA", o_ID_WRA, md.dst);
                check("rnd_ALUop", o_ID_ALUop, md.alu);
                check("rnd_illegal", o_ID_illegal, !md.legal);
                if (md.legal && ir_m != 32'h0) begin
                    check("rnd_rd1", o_ID_rd1, read_m(int'(ir_m[25:21])));
                    check("rnd_rd2", o_ID_rd2, read_m(int'(ir_m[20:16])));
                end
                iss = md.wr ? md.dst : -1;
            end
            @(posedge clk);
            if (we_r && a_r != 0) regs_m[a_r] = d_r;
            h1 = h0;
            h0 = iss;
            if (!stall_e) ir_m = nxt;
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
